instr_mem_responder: RTL and testbench

Responder end of the core instruction-fetch interface (req/gnt/rvalid/rdata). It models the instruction memory that drives `instr_rvalid`/`instr_rdata` into the core and the fetch trackers. It accepts word-aligned fetch requests, returns data in order after a fixed programmable latency, and bounds the number of outstanding fetches. It supports wait-state injection and a write-only preload port for test images.

---
 rtl/instr_mem_responder.sv | 115 +++++++++++
 tb/tb_instr_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder
//
// Instruction-memory responder for the core fetch interface (req/gnt/rvalid/rdata).
// Fetches are word-aligned and answered in order after a fixed LATENCY. At most
// MAX_OUTSTANDING fetches may be granted and still unanswered. A write-only preload
// port fills the storage with test images.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   instr_req     fetch request, held by the core until granted
//   instr_addr    fetch byte address, sampled only in the grant cycle
//   instr_gnt     request accepted this cycle (combinational)
//   instr_rvalid  one-cycle pulse per fetch, LATENCY cycles after its grant
//   instr_rdata   fetched word; holds the last returned word while rvalid is low
//   gnt_stall     wait-state injection, forces instr_gnt low
//   load_en       preload write strobe (honoured during reset too)
//   load_addr     preload byte address
//   load_data     preload word
//
// Parameter legal ranges: LATENCY 1..8, MAX_OUTSTANDING 1..LATENCY+1,
// MEM_DEPTH a power of two with ADDR_WIDTH >= log2(MEM_DEPTH)+2.

module instr_mem_responder #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_gnt,
    output logic                  instr_rvalid,
    output logic [DATA_WIDTH-1:0] instr_rdata,
    input  logic                  gnt_stall,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    // Byte address -> word index; low two bits and bits above the array size are
    // dropped, so addresses wrap modulo MEM_DEPTH words.
    logic [IdxW-1:0] fetch_idx;
    logic [IdxW-1:0] load_idx;

    assign fetch_idx = instr_addr[IdxW+1:2];
    assign load_idx  = load_addr[IdxW+1:2];

    // Only part of each address is decoded; fold the rest away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr, load_addr};

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [CntW-1:0]       outstanding_q;
    logic [CntW-1:0]       outstanding_d;
    logic [LATENCY-1:0]    vld_q;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];
    logic                  slot_free;

    // Uses the registered count only: a response retiring this cycle does not
    // free a slot for a grant in the same cycle.
    assign slot_free    = outstanding_q < CntW'(MAX_OUTSTANDING);
    assign instr_gnt    = instr_req && !gnt_stall && !rst && slot_free;
    assign instr_rvalid = vld_q[LATENCY-1] && !rst;
    // The last stage only loads when a valid entry enters it, so it doubles as
    // the hold register for rdata between responses.
    assign instr_rdata  = dat_q[LATENCY-1];

    always_comb begin
        outstanding_d = outstanding_q;
        case ({instr_gnt, instr_rvalid})
            2'b10:   outstanding_d = outstanding_q + CntW'(1);
            2'b01:   outstanding_d = outstanding_q - CntW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Storage is never reset; preload writes land at the end of the cycle, so a
    // grant to the same word in that cycle still reads the old contents.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            vld_q         <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            vld_q[0]      <= instr_gnt;
            if (instr_gnt) begin
                dat_q[0] <= mem[fetch_idx];
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 3;
    localparam int unsigned MAXO  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_req;
    logic [AW-1:0] instr_addr;
    logic          instr_gnt;
    logic          instr_rvalid;
    logic [DW-1:0] instr_rdata;
    logic          gnt_stall;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    always #5 clk = ~clk;

    instr_mem_responder #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .MEM_DEPTH      (DEPTH),
        .LATENCY        (LAT),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_gnt   (instr_gnt),
        .instr_rvalid(instr_rvalid),
        .instr_rdata (instr_rdata),
        .gnt_stall   (gnt_stall),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    // Reference model: word array plus a queue of pending responses, each tagged
    // with the cycle in which it must appear.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [DW-1:0] mem_m [DEPTH];
    resp_t         pend[$];
    logic [DW-1:0] last_rdata = '0;
    logic          obs_gnt;
    logic          obs_rvalid;
    logic [DW-1:0] obs_rdata;

    function automatic int widx(input logic [AW-1:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle();
        rst       = 1'b0;
        instr_req = 1'b0;
        gnt_stall = 1'b0;
        load_en   = 1'b0;
    endtask

    // One clock cycle: compare outputs at the falling edge against the model,
    // advance the model, then step to just after the next rising edge.
    task automatic tick();
        logic          e_gnt;
        logic          e_rvalid;
        logic [DW-1:0] e_rdata;
        @(negedge clk);
        e_rvalid = !rst && (pend.size() > 0) && (pend[0].due == cyc);
        e_gnt    = instr_req && !gnt_stall && !rst && (pend.size() < int'(MAXO));
        e_rdata  = e_rvalid ? pend[0].data : last_rdata;
        obs_gnt    = instr_gnt;
        obs_rvalid = instr_rvalid;
        obs_rdata  = instr_rdata;
        check("gnt", DW'(obs_gnt), DW'(e_gnt));
        check("rvalid", DW'(obs_rvalid), DW'(e_rvalid));
        if (!rst) check("rdata", obs_rdata, e_rdata);
        if (rst) begin
            pend.delete();
            last_rdata = '0;
        end else begin
            if (e_rvalid) begin
                last_rdata = pend[0].data;
                void'(pend.pop_front());
            end
            if (e_gnt) pend.push_back('{cyc + int'(LAT), mem_m[widx(instr_addr)]});
        end
        if (load_en) mem_m[widx(load_addr)] = load_data;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // Ticks until an rvalid is seen (bounded); reports ticks taken and data.
    task automatic wait_rvalid(input string tag, output int n, output logic [DW-1:0] d);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n = i + 1;
            if (obs_rvalid) break;
        end
        check({tag, "_seen"}, DW'(obs_rvalid), DW'(1'b1));
        d = obs_rdata;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && pend.size() > 0; i++) tick();
        check("drained", DW'(pend.size()), '0);
    endtask

    initial begin
        int            n;
        logic [DW-1:0] d;
        logic [8:0]    gv;
        logic [8:0]    rv;
        logic [DW-1:0] rdat [9];
        logic [DW-1:0] tmp;

        idle();
        rst        = 1'b1;
        instr_addr = '0;
        load_addr  = '0;
        load_data  = '0;
        @(posedge clk);
        #1;

        // Preload the words used by the bench while reset is held.
        for (int i = 0; i < 16; i++) begin
            rst       = 1'b1;
            load_en   = 1'b1;
            load_addr = AW'(i * 4);
            load_data = $urandom();
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        idle();
        tick();
        check("reset_rvalid", DW'(obs_rvalid), '0);
        check("reset_rdata", obs_rdata, '0);

        // Basic fetch.
        load(32'h10, 32'h0000_2083);
        idle();
        instr_req  = 1'b1;
        instr_addr = 32'h10;
        tick();
        check("basic_gnt", DW'(obs_gnt), DW'(1'b1));
        idle();
        wait_rvalid("basic", n, d);
        check("basic_latency", DW'(n), DW'(LAT));
        check("basic_data", d, 32'h0000_2083);
        tick();
        check("basic_hold_rvalid", DW'(obs_rvalid), '0);
        check("basic_hold_rdata", obs_rdata, 32'h0000_2083);
        drain();

        // Back-to-back requests against the outstanding limit.
        load(32'h0, 32'hA);
        load(32'h4, 32'hB);
        load(32'h8, 32'hC);
        idle();
        instr_addr = 32'h0;
        for (int i = 0; i < 9; i++) begin
            instr_req = 1'b1;
            tick();
            gv[i]   = obs_gnt;
            rv[i]   = obs_rvalid;
            rdat[i] = obs_rdata;
            if (obs_gnt) instr_addr = instr_addr + 32'h4;
        end
        idle();
        check("limit_gnt_pattern", DW'(gv), 32'h133);
        check("limit_rvalid_pattern", DW'(rv), 32'h198);
        check("b2b_data0", rdat[3], 32'hA);
        check("b2b_data1", rdat[4], 32'hB);
        check("b2b_data2", rdat[7], 32'hC);
        drain();

        // Wait states.
        idle();
        instr_req  = 1'b1;
        instr_addr = 32'h4;
        gnt_stall  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_gnt_low", DW'(obs_gnt), '0);
        end
        gnt_stall = 1'b0;
        tick();
        check("stall_release_gnt", DW'(obs_gnt), DW'(1'b1));
        idle();
        wait_rvalid("stall", n, d);
        check("stall_latency", DW'(n), DW'(LAT));
        check("stall_data", d, 32'hB);
        drain();

        // Wrap-around addressing.
        load(32'h4, 32'h1234);
        idle();
        instr_req  = 1'b1;
        instr_addr = 32'h1004;
        tick();
        idle();
        wait_rvalid("wrap", n, d);
        check("wrap_data", d, 32'h1234);
        drain();

        // Preload colliding with a grant: old word returned, new word next time.
        load(32'h8, 32'h44);
        idle();
        instr_req  = 1'b1;
        instr_addr = 32'h8;
        load_en    = 1'b1;
        load_addr  = 32'h8;
        load_data  = 32'h55;
        tick();
        check("collide_gnt", DW'(obs_gnt), DW'(1'b1));
        idle();
        wait_rvalid("collide_old", n, d);
        check("collide_old_data", d, 32'h44);
        instr_req  = 1'b1;
        instr_addr = 32'h8;
        tick();
        idle();
        wait_rvalid("collide_new", n, d);
        check("collide_new_data", d, 32'h55);
        drain();

        // Reset with a fetch in flight.
        idle();
        instr_req  = 1'b1;
        instr_addr = 32'hC;
        tick();
        check("rstflight_gnt", DW'(obs_gnt), DW'(1'b1));
        idle();
        rst = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstflight_no_rvalid", DW'(obs_rvalid), '0);
            check("rstflight_rdata_zero", obs_rdata, '0);
        end
        instr_req  = 1'b1;
        instr_addr = 32'h10;
        tick();
        idle();
        wait_rvalid("post_reset", n, d);
        check("post_reset_latency", DW'(n), DW'(LAT));
        check("post_reset_data", d, 32'h0000_2083);
        drain();

        // Randomized traffic; requests are held until granted.
        idle();
        obs_gnt = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!instr_req || obs_gnt) begin
                instr_req  = ($urandom_range(0, 99) < 65);
                tmp        = $urandom();
                instr_addr = (tmp & 32'hFFFF_F003) | AW'($urandom_range(0, 15) << 2);
            end
            gnt_stall = ($urandom_range(0, 99) < 25);
            rst       = ($urandom_range(0, 99) < 2);
            load_en   = ($urandom_range(0, 99) < 20);
            tmp       = $urandom();
            load_addr = (tmp & 32'hFFFF_F003) | AW'($urandom_range(0, 15) << 2);
            load_data = $urandom();
            tick();
        end
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
